// File: rtl/idex_pkg.sv
// ID/EX pipeline register shared types: default widths and payload bundle.
package idex_pkg;

  localparam int IDEX_DATA_W = 32;
  localparam int IDEX_REG_W  = 5;
  localparam int IDEX_WB_W   = 2;
  localparam int IDEX_M_W    = 3;
  localparam int IDEX_EX_W   = 4;
  localparam int IDEX_CNT_W  = 16;

  typedef struct packed {
    logic [IDEX_WB_W-1:0]   wb;
    logic [IDEX_M_W-1:0]    m;
    logic [IDEX_EX_W-1:0]   ex;
    logic [IDEX_REG_W-1:0]  rs;
    logic [IDEX_REG_W-1:0]  rt;
    logic [IDEX_REG_W-1:0]  rd;
    logic [IDEX_DATA_W-1:0] bus_a;
    logic [IDEX_DATA_W-1:0] bus_b;
    logic [IDEX_DATA_W-1:0] imd;
  } idex_payload_t;

  function automatic int idex_pay_w(
    input int wb_w,
    input int m_w,
    input int ex_w,
    input int reg_w,
    input int data_w
  );
    return wb_w + m_w + ex_w + 3 * reg_w + 3 * data_w;
  endfunction

  localparam int IDEX_PAY_W = $bits(idex_payload_t);

endpackage

// File: rtl/idex_pipe_reg_skid_slot.sv
// One-entry skid slot for the ID/EX register.
// Holds a single payload accepted while the EX side is stalled.
module idex_skid_slot
  import idex_pkg::*;
#(
  parameter int W = IDEX_PAY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout
);

  logic         full_q;
  logic         full_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      data_d = din;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake and bubble counter.
// Define IDEX_PIPE_SKID_EN to add a one-entry skid with registered in_ready.
module idex_pipe_reg
  import idex_pkg::*;
#(
  parameter int DATA_W = IDEX_DATA_W,
  parameter int REG_W  = IDEX_REG_W,
  parameter int WB_W   = IDEX_WB_W,
  parameter int M_W    = IDEX_M_W,
  parameter int EX_W   = IDEX_EX_W,
  parameter int CNT_W  = IDEX_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [M_W-1:0]    in_m,
  input  logic [EX_W-1:0]   in_ex,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_bus_a,
  input  logic [DATA_W-1:0] in_bus_b,
  input  logic [DATA_W-1:0] in_imd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   out_wb,
  output logic [M_W-1:0]    out_m,
  output logic [EX_W-1:0]   out_ex,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_bus_a,
  output logic [DATA_W-1:0] out_bus_b,
  output logic [DATA_W-1:0] out_imd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int CW = WB_W + M_W + EX_W;
  localparam int PW = idex_pay_w(WB_W, M_W, EX_W, REG_W, DATA_W);

  logic [PW-1:0]    in_pay;
  logic [PW-1:0]    load_pay;
  logic [PW-1:0]    pay_q;
  logic [PW-1:0]    pay_d;
  logic             valid_q;
  logic             valid_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             out_free;
  logic             in_fire;
  logic             load;

  assign in_pay = {in_wb, in_m, in_ex,
                   in_rs, in_rt, in_rd,
                   in_bus_a, in_bus_b, in_imd};

  assign out_free = !valid_q || out_ready;

`ifdef IDEX_PIPE_SKID_EN
  logic          rdy_q;
  logic          rdy_d;
  logic          skid_full;
  logic          skid_load;
  logic          skid_unload;
  logic [PW-1:0] skid_pay;

  assign in_ready    = rdy_q;
  assign in_fire     = in_valid && rdy_q;
  assign skid_load   = !flush && !out_free && in_fire;
  assign skid_unload = !flush && out_free && skid_full;

  idex_skid_slot #(
    .W (PW)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush),
    .load   (skid_load),
    .unload (skid_unload),
    .din    (in_pay),
    .full   (skid_full),
    .dout   (skid_pay)
  );

  // The skid is older than anything on the input, so it drains first.
  assign load     = out_free && (skid_full || in_fire);
  assign load_pay = skid_full ? skid_pay : in_pay;

  always_comb begin
    rdy_d = !(skid_load || (skid_full && !skid_unload));
    if (flush) begin
      rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= rdy_d;
    end
  end
`else
  assign in_ready = out_free;
  assign in_fire  = in_valid && out_free;
  assign load     = in_fire;
  assign load_pay = in_pay;
`endif

  always_comb begin
    valid_d = valid_q;
    pay_d   = pay_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (out_free) begin
      valid_d = load;
      if (load) begin
        pay_d = load_pay;
      end
    end
    // Bubbles carry zero control; data fields keep their last value.
    if (!valid_d) begin
      pay_d[PW-1 -: CW] = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!valid_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign bubble_cnt = cnt_q;
  assign {out_wb, out_m, out_ex,
          out_rs, out_rt, out_rd,
          out_bus_a, out_bus_b, out_imd} = pay_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed testbench for idex_pipe_reg with a payload scoreboard.
// Covers both builds: with and without IDEX_PIPE_SKID_EN.
module tb_idex_pipe_reg;
  import idex_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_wb;
  logic [2:0]  out_m;
  logic [3:0]  out_ex;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [31:0] out_bus_a;
  logic [31:0] out_bus_b;
  logic [31:0] out_imd;
  logic [3:0]  bubble_cnt;

  idex_payload_t cur;
  idex_payload_t exp_q[$];
  idex_payload_t p1;

  int  passed = 0;
  int  total  = 0;
  bit  last_in_fire;
  bit  last_in_ready;

  idex_pipe_reg #(
    .DATA_W (32),
    .REG_W  (5),
    .WB_W   (2),
    .M_W    (3),
    .EX_W   (4),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wb      (cur.wb),
    .in_m       (cur.m),
    .in_ex      (cur.ex),
    .in_rs      (cur.rs),
    .in_rt      (cur.rt),
    .in_rd      (cur.rd),
    .in_bus_a   (cur.bus_a),
    .in_bus_b   (cur.bus_b),
    .in_imd     (cur.imd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_wb     (out_wb),
    .out_m      (out_m),
    .out_ex     (out_ex),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_bus_a  (out_bus_a),
    .out_bus_b  (out_bus_b),
    .out_imd    (out_imd),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

  function automatic logic [119:0] out_pay();
    return {out_wb, out_m, out_ex, out_rs, out_rt, out_rd,
            out_bus_a, out_bus_b, out_imd};
  endfunction

  function automatic idex_payload_t mk();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[119:0];
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    bit inf;
    bit outf;
    idex_payload_t e;
    #1;
    inf  = in_valid && in_ready;
    outf = out_valid && out_ready;
    last_in_ready = in_ready;
    if (outf) begin
      chk("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_payload", 128'(out_pay()), 128'(e));
      end
    end
    if (flush) exp_q.delete();
    else if (inf) exp_q.push_back(cur);
    last_in_fire = inf;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    cur       = '0;
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_payload", 128'(out_pay()), 128'd0);
    chk("rst_bubble", 128'(bubble_cnt), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);

    // Basic single transfer
    cur       = '0;
    cur.ex    = 4'hA;
    cur.bus_a = 32'h1234;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    chk("basic_valid", 128'(out_valid), 128'd1);
    chk("basic_ex", 128'(out_ex), 128'hA);
    chk("basic_bus_a", 128'(out_bus_a), 128'h1234);
    in_valid = 1'b0;
    step();
    chk("bubble_valid", 128'(out_valid), 128'd0);
    chk("bubble_ctrl", 128'({out_wb, out_m, out_ex}), 128'd0);
    chk("bubble_data_hold", 128'(out_bus_a), 128'h1234);

    // Stall for three cycles
    cur      = mk();
    p1       = cur;
    in_valid = 1'b1;
    step();
    chk("stall_load", 128'(out_valid), 128'd1);
    out_ready = 1'b0;
    cur       = mk();
    for (int k = 0; k < 3; k++) begin
      step();
      if (last_in_fire) cur = mk();
`ifdef IDEX_PIPE_SKID_EN
      chk("stall_in_ready", 128'(last_in_ready), 128'(k == 0));
`else
      chk("stall_in_ready", 128'(last_in_ready), 128'd0);
`endif
      chk("stall_valid", 128'(out_valid), 128'd1);
      chk("stall_payload", 128'(out_pay()), 128'(p1));
    end
`ifdef IDEX_PIPE_SKID_EN
    chk("skid_held", 128'(exp_q.size()), 128'd2);
`else
    chk("noskid_held", 128'(exp_q.size()), 128'd1);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_in_fire) in_valid = 1'b0;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'd0);
    chk("drain_valid", 128'(out_valid), 128'd0);

    // Flush while stalled drops held entries and same-cycle input
    cur      = mk();
    in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    cur       = mk();
`ifdef IDEX_PIPE_SKID_EN
    step();
    cur = mk();
`endif
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 128'(out_valid), 128'd0);
    chk("flush_ctrl", 128'({out_wb, out_m, out_ex}), 128'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_no_ghost", 128'(out_valid), 128'd0);
    end
    chk("flush_in_ready", 128'(in_ready), 128'd1);

    // Reset pulse then 8-deep back-to-back stream
    rst_n = 1'b0;
    #1;
    chk("pulse1_valid", 128'(out_valid), 128'd0);
    chk("pulse1_bubble", 128'(bubble_cnt), 128'd0);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cur = mk();
      step();
      chk("stream_valid", 128'(out_valid), 128'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_bubble", 128'(bubble_cnt), 128'd1);
    chk("stream_empty", 128'(exp_q.size()), 128'd0);

    // Idle: counter increments then saturates
    for (int k = 0; k < 3; k++) step();
    chk("idle_bubble_4", 128'(bubble_cnt), 128'd4);
    for (int k = 0; k < 17; k++) step();
    chk("idle_bubble_sat", 128'(bubble_cnt), 128'd15);
    step();
    chk("idle_bubble_hold", 128'(bubble_cnt), 128'd15);

    rst_n = 1'b0;
    #1;
    chk("pulse2_bubble", 128'(bubble_cnt), 128'd0);
    chk("pulse2_valid", 128'(out_valid), 128'd0);
    #3;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/idex_pipe_reg.md
IDEX_PIPE_REG -- requirements
Module: idex_pipe_reg

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- DATA_W, 32, width of bus_a, bus_b, imd
- REG_W, 5, width of rs, rt, rd
- WB_W, 2, writeback control width
- M_W, 3, memory control width
- EX_W, 4, execute control width
- CNT_W, 16, bubble counter width
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- in_valid, in, 1, ID stage presents an instruction
- in_ready, out, 1, stage can accept
- in_wb/in_m/in_ex, in, WB_W/M_W/EX_W, control fields
- in_rs/in_rt/in_rd, in, REG_W each, register specifiers
- in_bus_a/in_bus_b/in_imd, in, DATA_W each, operands and immediate
- flush, in, 1, synchronous squash of all held instructions
- out_valid, out, 1, EX stage instruction valid
- out_ready, in, 1, EX stage accepts
- out_wb/out_m/out_ex/out_rs/out_rt/out_rd/out_bus_a/out_bus_b/out_imd, out, matching widths, registered payload
- bubble_cnt, out, CNT_W, count of cycles with out_valid low
REQ-003 Clock port SHALL be clk; reset SHALL be rst_n, asynchronous, active-low.

Function
REQ-004 Input transfer SHALL occur on rising clk when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-005 Latency SHALL be exactly 1 cycle from input transfer to out_valid when the output is empty or draining.
REQ-006 While out_valid && !out_ready, all out_* payload SHALL remain stable.
REQ-007 Whenever out_valid is 0, out_wb, out_m, out_ex SHALL be all-zero (bubble); data fields hold last value.
REQ-008 flush SHALL have highest priority: next cycle out_valid=0, control fields zero, any same-cycle input transfer discarded, buffered entries dropped.
REQ-009 Instruction order SHALL be preserved; no instruction duplicated or lost except by flush.
REQ-010 bubble_cnt SHALL increment by 1 each cycle out_valid is 0, saturating at all-ones.
REQ-011 Simultaneous input and output transfer SHALL replace the held entry with no bubble (full throughput).

Reset
REQ-012 While rst_n=0: out_valid=0, all out_* payload=0, bubble_cnt=0, skid entry empty; in_ready=1 after release.
REQ-013 Reset asserted mid-transfer SHALL discard all held instructions; no partial update visible.

Configuration
REQ-014 Macro IDEX_PIPE_SKID_EN: when defined, a one-entry skid buffer SHALL be present and in_ready SHALL be a registered signal equal to !skid_full; an input accepted while output stalled enters the skid and moves to output on the next output transfer.
REQ-015 Without IDEX_PIPE_SKID_EN: no skid; in_ready SHALL be combinational out_ready || !out_valid.

Structure
REQ-016 Shared package idex_pkg SHALL hold default width constants and a packed payload struct type (wb, m, ex, rs, rt, rd, bus_a, bus_b, imd).
REQ-017 The skid buffer SHALL be sub-module idex_skid_slot, instantiated only under IDEX_PIPE_SKID_EN.

Verification
REQ-018 Reset then in_valid=1, in_ex=4'hA, in_bus_a=32'h1234 with out_ready=1 -> next cycle out_valid=1, out_ex=4'hA, out_bus_a=32'h1234.
REQ-019 out_ready=0 for 3 cycles with out_valid=1 -> payload stable all 3 cycles; without skid in_ready=0; with skid one extra input accepted, then in_ready=0, both emerge in order.
REQ-020 flush=1 with in_valid=1, in_ready=1 -> next cycle out_valid=0, out_wb=out_m=out_ex=0, input never appears.
REQ-021 Back-to-back stream of 8 instructions, out_ready=1 -> 8 consecutive out_valid cycles, correct order, bubble_cnt unchanged.
REQ-022 Idle 20 cycles with CNT_W=4 -> bubble_cnt saturates at 15; rst_n pulse low -> bubble_cnt=0 and out_valid=0 immediately.
